// File: rtl/dmem_port_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_port_arbiter
//
// Purpose:
//   Shares a single-port data memory between the pipeline MEM stage (port P)
//   and a DMA/loader engine (port D). The pipeline normally wins. D is
//   force-granted once it has lost MAX_WAIT consecutive cycles, and it may
//   then keep the port for a burst of up to MAX_BURST beats. Read data goes
//   back to whichever port owned the read, one cycle after the grant.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   pipe_addr/wdata/rd/wr      P request (rd and wr together means write only)
//   pipe_stall                 P requesting but not granted (combinational)
//   pipe_rdata/pipe_rvalid     P read return, registered
//   dma_addr/wdata/rd/wr/last  D request; last marks the final burst beat
//   dma_gnt                    D beat accepted this cycle (combinational)
//   dma_rdata/dma_rvalid       D read return, registered
//   mem_addr/wdata/read/write  muxed memory request from the granted port
//   mem_rdata                  memory read data, valid in the mem_read cycle
//   conflict_cnt               saturating count of cycles where both ports request
// ---------------------------------------------------------------------------
module dmem_port_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_WAIT  = 4,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] pipe_addr,
    input  logic [DATA_W-1:0] pipe_wdata,
    input  logic              pipe_rd,
    input  logic              pipe_wr,
    output logic              pipe_stall,
    output logic [DATA_W-1:0] pipe_rdata,
    output logic              pipe_rvalid,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    input  logic              dma_rd,
    input  logic              dma_wr,
    input  logic              dma_last,
    output logic              dma_gnt,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              dma_rvalid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic [15:0]       conflict_cnt
);

    localparam int WAIT_W  = $clog2(MAX_WAIT + 1);
    localparam int BURST_W = $clog2(MAX_BURST + 1);

    localparam logic [WAIT_W-1:0]  WAIT_LIMIT = WAIT_W'(MAX_WAIT);
    localparam logic [BURST_W-1:0] BURST_END  = BURST_W'(MAX_BURST - 1);

    localparam logic S_PIPE = 1'b0;
    localparam logic S_DMA  = 1'b1;

    logic               state_q, state_d;
    logic [WAIT_W-1:0]  wait_cnt_q, wait_cnt_d;
    logic [BURST_W-1:0] burst_cnt_q, burst_cnt_d;
    logic [15:0]        conflict_q, conflict_d;
    logic               pipe_rvalid_q, pipe_rvalid_d;
    logic               dma_rvalid_q, dma_rvalid_d;
    logic [DATA_W-1:0]  pipe_rdata_q, pipe_rdata_d;
    logic [DATA_W-1:0]  dma_rdata_q, dma_rdata_d;

    logic pipe_req, dma_req;
    logic pipe_grant, dma_grant;

    assign pipe_req = pipe_rd | pipe_wr;
    assign dma_req  = dma_rd | dma_wr;

    // Grant and state transitions. In S_PIPE the pipeline wins unless D has
    // already waited MAX_WAIT cycles; a non-final D beat there opens a burst.
    // In S_DMA, D keeps the port as long as it keeps requesting, until the
    // last beat or the burst length limit; an idle D hands the port straight
    // back so the pipeline is never left waiting on an empty burst.
    always_comb begin
        pipe_grant  = 1'b0;
        dma_grant   = 1'b0;
        state_d     = state_q;
        burst_cnt_d = burst_cnt_q;
        case (state_q)
            S_PIPE: begin
                if (dma_req && (!pipe_req || wait_cnt_q == WAIT_LIMIT)) begin
                    dma_grant = 1'b1;
                    if (!dma_last && (MAX_BURST > 1)) begin
                        state_d     = S_DMA;
                        burst_cnt_d = BURST_W'(1);
                    end
                end else if (pipe_req) begin
                    pipe_grant = 1'b1;
                end
            end
            S_DMA: begin
                if (dma_req) begin
                    dma_grant = 1'b1;
                    if (dma_last || burst_cnt_q == BURST_END) begin
                        state_d     = S_PIPE;
                        burst_cnt_d = '0;
                    end else begin
                        burst_cnt_d = burst_cnt_q + BURST_W'(1);
                    end
                end else begin
                    pipe_grant  = pipe_req;
                    state_d     = S_PIPE;
                    burst_cnt_d = '0;
                end
            end
            default: begin
                state_d     = S_PIPE;
                burst_cnt_d = '0;
            end
        endcase
    end

    // Starvation counter: counts consecutive lost D cycles and saturates at
    // the force-grant threshold; any grant or idle cycle starts it over.
    always_comb begin
        wait_cnt_d = '0;
        if (dma_req && !dma_grant) begin
            wait_cnt_d = (wait_cnt_q == WAIT_LIMIT) ? wait_cnt_q
                                                    : wait_cnt_q + WAIT_W'(1);
        end
    end

    // Memory request mux. With no owner everything is driven to zero so the
    // memory never sees a stale address or strobe. A write wins over a
    // simultaneous read from the same port.
    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (pipe_grant) begin
            mem_addr  = pipe_addr;
            mem_wdata = pipe_wdata;
            mem_read  = pipe_rd & ~pipe_wr;
            mem_write = pipe_wr;
        end else if (dma_grant) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_read  = dma_rd & ~dma_wr;
            mem_write = dma_wr;
        end
    end

    // Read return and conflict statistics. Read data is captured only for
    // the port that owned a read this cycle; otherwise the data holds.
    always_comb begin
        pipe_rvalid_d = pipe_grant & pipe_rd & ~pipe_wr;
        dma_rvalid_d  = dma_grant & dma_rd & ~dma_wr;
        pipe_rdata_d  = pipe_rvalid_d ? mem_rdata : pipe_rdata_q;
        dma_rdata_d   = dma_rvalid_d ? mem_rdata : dma_rdata_q;
        conflict_d    = conflict_q;
        if (pipe_req && dma_req && conflict_q != 16'hFFFF) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    // State registers. Reset abandons any burst in progress and drops a read
    // return that would otherwise appear in the following cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_PIPE;
            wait_cnt_q    <= '0;
            burst_cnt_q   <= '0;
            conflict_q    <= '0;
            pipe_rvalid_q <= 1'b0;
            dma_rvalid_q  <= 1'b0;
            pipe_rdata_q  <= '0;
            dma_rdata_q   <= '0;
        end else begin
            state_q       <= state_d;
            wait_cnt_q    <= wait_cnt_d;
            burst_cnt_q   <= burst_cnt_d;
            conflict_q    <= conflict_d;
            pipe_rvalid_q <= pipe_rvalid_d;
            dma_rvalid_q  <= dma_rvalid_d;
            pipe_rdata_q  <= pipe_rdata_d;
            dma_rdata_q   <= dma_rdata_d;
        end
    end

    assign pipe_stall   = pipe_req & ~pipe_grant;
    assign dma_gnt      = dma_grant;
    assign pipe_rdata   = pipe_rdata_q;
    assign pipe_rvalid  = pipe_rvalid_q;
    assign dma_rdata    = dma_rdata_q;
    assign dma_rvalid   = dma_rvalid_q;
    assign conflict_cnt = conflict_q;

endmodule
